// File: rtl/fma_sched_pkg.sv
// Shared FP16 constants and the issue-tag layout for the FMA scheduler.
// Pure declarations: no latency, no flow control.
package fma_sched_pkg;
  localparam int WIDTH    = 16;
  localparam int EXP_BITS = 5;
  localparam int MAN_BITS = 10;
  localparam int BIAS     = 15;

  // Tag id width is sized for the default requester count.
  localparam int TAG_NUM_REQ = 4;
  localparam int ID_BITS     = $clog2(TAG_NUM_REQ);

  typedef struct packed {
    logic               valid;
    logic [ID_BITS-1:0] id;
  } tag_t;
endpackage

// File: rtl/fma_scheduler_rr_arbiter.sv
// Round-robin grant: lowest requesting index at or after ptr, wrapping; zero latency.
// No backpressure of its own; en low suppresses every grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 en,
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 hit
);
  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!hit && en && req[(int'(ptr) + k) % N]) begin
        hit = 1'b1;
        idx = ($clog2(N))'((int'(ptr) + k) % N);
      end
    end
    if (hit) gnt[idx] = 1'b1;
  end
endmodule

// File: rtl/fma_scheduler.sv
// Shares one fixed-latency FP16 FMA among NUM_REQ requesters; response LATENCY+2 cycles after grant.
// Grants are combinational and gated by issue_en; responses have no backpressure.
module fma_scheduler
  import fma_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_en,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*WIDTH-1:0] req_c,
  output logic [WIDTH-1:0]         fp16_a,
  output logic [WIDTH-1:0]         fp16_b,
  output logic [WIDTH-1:0]         fp16_c,
  output logic                     in_valid,
  input  logic [WIDTH-1:0]         fp16_d,
  input  logic                     out_valid,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy,
  output logic                     latency_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LATENCY + 1) + 1;

  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      gnt_idx;
  logic [IW-1:0]      issue_id;
  logic               gnt_hit;
  logic [NUM_REQ-1:0] gnt;
  logic [CW-1:0]      outstanding;
  tag_t               tag_pipe [LATENCY];
  tag_t               head;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .en  (issue_en && !reset),
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .hit (gnt_hit)
  );

  assign req_ready = gnt;
  assign head      = tag_pipe[LATENCY-1];
  assign busy      = (outstanding != '0) || in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      issue_id    <= '0;
      in_valid    <= 1'b0;
      fp16_a      <= '0;
      fp16_b      <= '0;
      fp16_c      <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      latency_err <= 1'b0;
      outstanding <= '0;
      for (int i = 0; i < LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      in_valid <= gnt_hit;
      if (gnt_hit) begin
        fp16_a   <= req_a[gnt_idx*WIDTH +: WIDTH];
        fp16_b   <= req_b[gnt_idx*WIDTH +: WIDTH];
        fp16_c   <= req_c[gnt_idx*WIDTH +: WIDTH];
        issue_id <= gnt_idx;
        rr_ptr   <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end

      // The tag follows in_valid so its head arrival lines up with the FMA result.
      tag_pipe[0] <= '{valid: in_valid, id: ID_BITS'(issue_id)};
      for (int i = 1; i < LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];

      rsp_valid <= '0;
      if (head.valid && out_valid) begin
        rsp_valid <= NUM_REQ'(1) << head.id;
        rsp_data  <= fp16_d;
      end
      // Missing or unexpected result: tag or result is dropped, error latched.
      if (head.valid != out_valid) latency_err <= 1'b1;

      case ({in_valid, head.valid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end
endmodule

// File: tb/tb_fma_scheduler.sv
// Directed bench for fma_scheduler with a behavioural fixed-latency FMA stub.
module tb_fma_scheduler;
  localparam int NR  = 4;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_en;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [NR*16-1:0] req_a, req_b, req_c;
  logic [15:0]   fp16_a, fp16_b, fp16_c, fp16_d;
  logic          in_valid, out_valid;
  logic [NR-1:0] rsp_valid;
  logic [15:0]   rsp_data;
  logic          busy, latency_err;

  int checks = 0;
  int errors = 0;

  logic        mdl_init = 1'b1;
  logic        slow_flag = 1'b0;
  logic        spurious = 1'b0;
  logic        mv_v [16];
  logic        mv_s [16];
  logic [15:0] mv_d [16];

  always #5 clk = ~clk;

  fma_scheduler #(.NUM_REQ(NR), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .issue_en(issue_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .fp16_a(fp16_a), .fp16_b(fp16_b), .fp16_c(fp16_c), .in_valid(in_valid),
    .fp16_d(fp16_d), .out_valid(out_valid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .latency_err(latency_err)
  );

  // Exact FP16 results for the operand sets used below; anything else yields NaN.
  function automatic logic [15:0] fake_fma(input logic [15:0] a, b, c);
    if (a == 16'h3c00 && b == 16'h4000 && c == 16'h3c00) return 16'h4200;
    if (a == 16'h3c00 && c == 16'h0000) return b;
    return 16'h7e00;
  endfunction

  // FMA stub: result LAT cycles after in_valid, or LAT+1 when slow_flag marked the op.
  always @(posedge clk) begin
    if (mdl_init) begin
      for (int i = 0; i < 16; i++) begin
        mv_v[i] <= 1'b0; mv_s[i] <= 1'b0; mv_d[i] <= '0;
      end
    end else begin
      mv_v[0] <= in_valid;
      mv_s[0] <= slow_flag;
      mv_d[0] <= fake_fma(fp16_a, fp16_b, fp16_c);
      for (int i = 1; i < 16; i++) begin
        mv_v[i] <= mv_v[i-1]; mv_s[i] <= mv_s[i-1]; mv_d[i] <= mv_d[i-1];
      end
    end
  end

  assign out_valid = spurious | (mv_v[LAT-1] & ~mv_s[LAT-1]) | (mv_v[LAT] & mv_s[LAT]);
  assign fp16_d    = (mv_v[LAT] & mv_s[LAT]) ? mv_d[LAT] : mv_d[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  exp_rdy [16];
    logic [3:0]  exp_rsp [16];
    logic [15:0] bval [4];
    bval = '{16'h3c00, 16'h4000, 16'h4200, 16'h4400};

    // ---- reset state, with requests pending during reset ----
    reset = 1'b1; issue_en = 1'b1; req_valid = 4'b1111;
    req_a = '0; req_b = '0; req_c = '0;
    tick(); tick(); tick();
    mdl_init = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_in_valid", in_valid, 1'b0);
    chk("rst_fp16_a", fp16_a, 16'h0000);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_latency_err", latency_err, 1'b0);

    // ---- single issue: 1.0*2.0+1.0 = 3.0 ----
    do_reset();
    req_a = {16'h0, 16'h0, 16'h0, 16'h3c00};
    req_b = {16'h0, 16'h0, 16'h0, 16'h4000};
    req_c = {16'h0, 16'h0, 16'h0, 16'h3c00};
    req_valid = 4'b0001;
    #1;
    chk("single_ready_c0", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("single_in_valid_c1", in_valid, 1'b1);
    chk("single_fp16_a", fp16_a, 16'h3c00);
    chk("single_fp16_b", fp16_b, 16'h4000);
    chk("single_fp16_c", fp16_c, 16'h3c00);
    chk("single_busy_c1", busy, 1'b1);
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk("single_no_rsp_early", rsp_valid, 4'b0000);
    end
    tick();
    chk("single_rsp_valid_c6", rsp_valid, 4'b0001);
    chk("single_rsp_data_c6", rsp_data, 16'h4200);
    chk("single_busy_c6", busy, 1'b0);
    chk("single_no_err", latency_err, 1'b0);

    // ---- full contention for 8 cycles ----
    req_a = {4{16'h3c00}};
    req_b = {bval[3], bval[2], bval[1], bval[0]};
    req_c = '0;
    do_reset();
    exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    exp_rsp = '{4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0001, 4'b0010,
                4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0, 4'b0};
    for (int k = 0; k < 16; k++) begin
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      chk("rr_ready", req_ready, exp_rdy[k]);
      chk("rr_rsp_valid", rsp_valid, exp_rsp[k]);
      if (k >= 6 && k < 14) chk("rr_rsp_data", rsp_data, bval[(k-6)%4]);
      if (k >= 1 && k <= 8) chk("rr_in_valid", in_valid, 1'b1);
      tick();
    end
    chk("rr_busy_idle", busy, 1'b0);
    chk("rr_no_err", latency_err, 1'b0);

    // ---- issue_en low in cycles 2..5 ----
    do_reset();
    exp_rdy = '{4'b0001, 4'b0010, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0100, 4'b1000,
                4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    exp_rsp = '{4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0001, 4'b0010,
                4'b0, 4'b0, 4'b0, 4'b0, 4'b0100, 4'b1000, 4'b0, 4'b0};
    for (int k = 0; k < 16; k++) begin
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      issue_en  = !(k >= 2 && k <= 5);
      #1;
      chk("hold_ready", req_ready, exp_rdy[k]);
      chk("hold_rsp_valid", rsp_valid, exp_rsp[k]);
      if (exp_rsp[k] != 4'b0) chk("hold_rsp_data", rsp_data, bval[(k < 12) ? k-6 : k-10]);
      if (k >= 2 && k <= 5) chk("hold_busy", busy, 1'b1);
      tick();
    end
    issue_en = 1'b1;
    chk("hold_no_err", latency_err, 1'b0);

    // ---- result one cycle late ----
    do_reset();
    slow_flag = 1'b1;
    req_valid = 4'b0100;
    #1;
    chk("late_ready", req_ready, 4'b0100);
    for (int k = 1; k <= 10; k++) begin
      tick();
      req_valid = '0;
      chk("late_no_rsp", rsp_valid, 4'b0000);
      chk("late_err", latency_err, (k >= 6) ? 1'b1 : 1'b0);
      if (k == 5) chk("late_busy_c5", busy, 1'b1);
      if (k == 6) chk("late_busy_c6", busy, 1'b0);
    end
    slow_flag = 1'b0;

    // ---- reset while an operation is in flight ----
    do_reset();
    req_valid = 4'b0010;
    #1;
    chk("mid_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    chk("mid_in_valid", in_valid, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_busy_after_rst", busy, 1'b0);
    chk("mid_err_after_rst", latency_err, 1'b0);
    for (int k = 4; k <= 8; k++) begin
      tick();
      chk("mid_no_rsp", rsp_valid, 4'b0000);
      chk("mid_err", latency_err, (k >= 6) ? 1'b1 : 1'b0);
      chk("mid_busy", busy, 1'b0);
    end

    // ---- spurious result with an empty pipe ----
    do_reset();
    #1;
    chk("spur_err_before", latency_err, 1'b0);
    spurious = 1'b1;
    tick();
    spurious = 1'b0;
    chk("spur_no_rsp", rsp_valid, 4'b0000);
    chk("spur_err", latency_err, 1'b1);
    tick();
    chk("spur_err_held", latency_err, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fma_scheduler.md
FMA_SCHEDULER -- requirements
Module: fma_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing one FP16 FMA datapath.
REQ-002 The block SHALL have parameter LATENCY, default 4: fixed FMA latency in cycles, in_valid to out_valid, legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1: single clock; one clock; all logic on posedge clk.
REQ-004 The block SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-005 The block SHALL have port issue_en, input, 1: when low, no new grants.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ: per-requester operation request.
REQ-007 The block SHALL have port req_ready, output, NUM_REQ: grant; handshake on req_valid[i]&&req_ready[i].
REQ-008 The block SHALL have port req_a/req_b/req_c, input, NUM_REQ*16 each: packed operands, requester i at bits [16i+15:16i].
REQ-009 The block SHALL have port fp16_a/fp16_b/fp16_c, output, 16 each: operands to the FMA (d = a*b + c).
REQ-010 The block SHALL have port in_valid, output, 1: operand strobe to the FMA.
REQ-011 The block SHALL have port fp16_d, input, 16: FMA result.
REQ-012 The block SHALL have port out_valid, input, 1: FMA result strobe.
REQ-013 The block SHALL have port rsp_valid, output, NUM_REQ: one-hot result strobe, no backpressure.
REQ-014 The block SHALL have port rsp_data, output, 16: result shared by all requesters.
REQ-015 The block SHALL have port busy, output, 1: operations in flight.
REQ-016 The block SHALL have port latency_err, output, 1: sticky protocol error.

Function
REQ-017 req_ready SHALL be combinational: at most one bit high, only when issue_en=1 and that requester's req_valid=1.
REQ-018 Arbitration SHALL be round-robin from pointer rr_ptr.
- The lowest index >= rr_ptr with req_valid wins, wrapping modulo NUM_REQ.
- After a handshake by requester g, rr_ptr SHALL become (g+1) mod NUM_REQ; otherwise rr_ptr holds.
REQ-019 A handshake in cycle t SHALL register that requester's operands into fp16_a/b/c and drive in_valid=1 in cycle t+1.
- With no handshake, in_valid=0 and fp16_a/b/c hold their last values.
- Back-to-back issue (one per cycle) SHALL be supported.
REQ-020 Each issue SHALL push {valid, id} into a LATENCY-deep tag shift register.
- The tag for in_valid at cycle t reaches the head at cycle t+LATENCY.
REQ-021 At a head-valid cycle with out_valid=1, the block SHALL register rsp_data=fp16_d and rsp_valid=one-hot(id) for one cycle.
- The response appears at cycle t+LATENCY+1, i.e. LATENCY+2 cycles after the handshake.
REQ-022 Protocol errors SHALL set latency_err=1, held until reset.
- Head valid with out_valid=0: the tag is discarded with no response.
- out_valid=1 with head invalid: the result is dropped.
REQ-023 An outstanding counter, clog2(LATENCY+1)+1 bits, SHALL track operations in flight.
- It increments on in_valid and decrements when a valid tag leaves the head.
- Both in one cycle leaves it unchanged; it never exceeds LATENCY.
REQ-024 busy SHALL equal (outstanding!=0) || in_valid.
REQ-025 Deasserting issue_en SHALL stop new grants only; in-flight operations SHALL complete and respond normally.

Reset
REQ-026 While reset=1, the block SHALL clear all state on the next posedge clk:
- req_ready=0, in_valid=0, fp16_a/b/c=0, rsp_valid=0, rsp_data=0, busy=0, latency_err=0.
- rr_ptr=0, tag pipe cleared, counter=0.
REQ-027 Reset mid-operation SHALL drop in-flight tags: an out_valid arriving after reset for a pre-reset issue SHALL produce no response and set latency_err.

Structure
REQ-028 Package fma_sched_pkg SHALL hold WIDTH=16, EXP_BITS=5, MAN_BITS=10, BIAS=15, and the tag struct typedef {logic valid; logic [$clog2(NUM_REQ)-1:0] id}.
REQ-029 The round-robin grant logic SHALL be the sub-module rr_arbiter (parameter N), instantiated once; everything else stays in fma_scheduler.

Verification
REQ-030 Single issue: req 0 sends a=3c00, b=4000, c=3c00 at cycle 0; the model FMA returns 4200 after LATENCY=4. Required: in_valid at cycle 1, rsp_valid=0001 with rsp_data=4200 at cycle 6, busy low at cycle 6.
REQ-031 Contention: all four req_valid held high for 8 cycles from reset. Required: grant order 0,1,2,3,0,1,2,3, one grant per cycle, and responses in the same id order.
REQ-032 issue_en low for cycles 2-5 with requests pending. Required: no req_ready in cycles 2-5, in-flight responses still delivered, arbitration resumes at the saved rr_ptr.
REQ-033 Model FMA delays one result to LATENCY+1. Required: that tag is dropped with no rsp_valid, latency_err=1 and held, and the late out_valid is dropped.
REQ-034 Reset asserted 2 cycles after an issue while the model still returns out_valid. Required: no rsp_valid, latency_err=1 after reset release, counter 0.
REQ-035 Spurious out_valid with an empty pipe. Required: no rsp_valid and latency_err=1.
